// File: rtl/rs_pkg.sv
// Shared types for the reservation-station entry buffer: the per-entry record,
// the issue payload, and the default field widths.
package rs_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int AGE_W  = 3;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst_tag;
        logic              src1_rdy;
        logic [TAG_W-1:0]  src1_tag;
        logic [DATA_W-1:0] src1_data;
        logic              src2_rdy;
        logic [TAG_W-1:0]  src2_tag;
        logic [DATA_W-1:0] src2_data;
        logic [AGE_W-1:0]  age;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst_tag;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } rs_issue_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: holds a dispatched micro-op, snoops the CDB
// for missing operands and keeps a saturating age for the arbiter.
module rs_entry
    import rs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              take,
    input  logic              age_inc,
    input  rs_entry_t         disp,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              valid,
    output logic              ready,
    output logic [AGE_W-1:0]  age,
    output rs_issue_t         payload
);

    rs_entry_t q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= '0;
        end else if (load) begin
            // Age starts at 1 so a strict greater-than arbiter can still pick it.
            q       <= disp;
            q.valid <= 1'b1;
            q.age   <= AGE_W'(1);
        end else if (take) begin
            q <= '0;
        end else if (q.valid) begin
            if (!q.src1_rdy && cdb_valid && (cdb_tag == q.src1_tag)) begin
                q.src1_rdy  <= 1'b1;
                q.src1_data <= cdb_data;
            end
            if (!q.src2_rdy && cdb_valid && (cdb_tag == q.src2_tag)) begin
                q.src2_rdy  <= 1'b1;
                q.src2_data <= cdb_data;
            end
            if (age_inc && (q.age != '1)) begin
                q.age <= q.age + 1'b1;
            end
        end
    end

    assign valid   = q.valid;
    assign ready   = q.valid & q.src1_rdy & q.src2_rdy;
    assign age     = q.age;
    assign payload = '{op: q.op, dst_tag: q.dst_tag, src1: q.src1_data, src2: q.src2_data};

endmodule

// File: rtl/rs_entry_buffer.sv
// Reservation-station entry storage between dispatch and the issue arbiter,
// with a one-deep registered issue slot toward the execution unit.
module rs_entry_buffer #(
    parameter int SIZE   = 4,
    parameter int TAG_W  = rs_pkg::TAG_W,
    parameter int DATA_W = rs_pkg::DATA_W,
    parameter int OP_W   = rs_pkg::OP_W,
    parameter int AGE_W  = rs_pkg::AGE_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  disp_valid_i,
    output logic                  disp_ready_o,
    input  logic [OP_W-1:0]       disp_op_i,
    input  logic [TAG_W-1:0]      disp_dst_tag_i,
    input  logic                  disp_src1_rdy_i,
    input  logic                  disp_src2_rdy_i,
    input  logic [TAG_W-1:0]      disp_src1_tag_i,
    input  logic [TAG_W-1:0]      disp_src2_tag_i,
    input  logic [DATA_W-1:0]     disp_src1_data_i,
    input  logic [DATA_W-1:0]     disp_src2_data_i,
    input  logic                  cdb_valid_i,
    input  logic [TAG_W-1:0]      cdb_tag_i,
    input  logic [DATA_W-1:0]     cdb_data_i,
    output logic [SIZE-1:0]       entry_free_o,
    output logic [SIZE-1:0]       entry_ready_o,
    output logic                  alloc_en_o,
    output logic [SIZE*AGE_W-1:0] age_o,
    input  logic [SIZE-1:0]       entry_allocate_i,
    input  logic [SIZE-1:0]       entry_issue_i,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [OP_W-1:0]       issue_op_o,
    output logic [TAG_W-1:0]      issue_dst_tag_o,
    output logic [DATA_W-1:0]     issue_src1_o,
    output logic [DATA_W-1:0]     issue_src2_o
);

    import rs_pkg::*;

    rs_entry_t        disp;
    logic [SIZE-1:0]  valid;
    logic [SIZE-1:0]  load;
    logic [SIZE-1:0]  take;
    logic [AGE_W-1:0] ages [SIZE];
    rs_issue_t        payloads [SIZE];
    rs_issue_t        pick;
    rs_issue_t        slot;
    logic             slot_valid;
    logic             slot_open;
    logic             alloc_ok;
    logic             issue_ok;
    logic             bypass1;
    logic             bypass2;

    // A source waiting on the tag being broadcast this cycle is captured at dispatch.
    assign bypass1 = cdb_valid_i && (cdb_tag_i == disp_src1_tag_i);
    assign bypass2 = cdb_valid_i && (cdb_tag_i == disp_src2_tag_i);

    always_comb begin
        disp           = '0;
        disp.op        = disp_op_i;
        disp.dst_tag   = disp_dst_tag_i;
        disp.src1_rdy  = disp_src1_rdy_i | bypass1;
        disp.src1_tag  = disp_src1_tag_i;
        disp.src1_data = disp_src1_rdy_i ? disp_src1_data_i : cdb_data_i;
        disp.src2_rdy  = disp_src2_rdy_i | bypass2;
        disp.src2_tag  = disp_src2_tag_i;
        disp.src2_data = disp_src2_rdy_i ? disp_src2_data_i : cdb_data_i;
    end

    assign entry_free_o = ~valid;
    assign disp_ready_o = |entry_free_o;
    assign alloc_en_o   = disp_valid_i & disp_ready_o;
    assign alloc_ok     = alloc_en_o && $onehot(entry_allocate_i) && |(entry_allocate_i & entry_free_o);
    assign slot_open    = ~slot_valid | issue_ready_i;
    assign issue_ok     = slot_open && $onehot(entry_issue_i) && |(entry_issue_i & entry_ready_o);
    assign load         = alloc_ok ? entry_allocate_i : '0;
    assign take         = issue_ok ? entry_issue_i : '0;

    for (genvar i = 0; i < SIZE; i++) begin : g_entry
        rs_entry u_entry (
            .clk       (clk_i),
            .reset     (reset_i),
            .flush     (flush_i),
            .load      (load[i]),
            .take      (take[i]),
            .age_inc   (alloc_en_o),
            .disp      (disp),
            .cdb_valid (cdb_valid_i),
            .cdb_tag   (cdb_tag_i),
            .cdb_data  (cdb_data_i),
            .valid     (valid[i]),
            .ready     (entry_ready_o[i]),
            .age       (ages[i]),
            .payload   (payloads[i])
        );
        assign age_o[i*AGE_W +: AGE_W] = ages[i];
    end

    always_comb begin
        pick = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (entry_issue_i[i]) pick = payloads[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            slot_valid <= 1'b0;
            slot       <= '0;
        end else if (issue_ok) begin
            slot_valid <= 1'b1;
            slot       <= pick;
        end else if (issue_ready_i) begin
            slot_valid <= 1'b0;
        end
    end

    assign issue_valid_o   = slot_valid;
    assign issue_op_o      = slot.op;
    assign issue_dst_tag_o = slot.dst_tag;
    assign issue_src1_o    = slot.src1;
    assign issue_src2_o    = slot.src2;

    a_alloc_target: assert property (@(posedge clk_i) disable iff (reset_i || flush_i)
        alloc_en_o |-> ($onehot(entry_allocate_i) && |(entry_allocate_i & entry_free_o)));

endmodule

// File: tb/tb_rs_entry_buffer.sv
// Directed bench for rs_entry_buffer: a queue-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_rs_entry_buffer;

    localparam int SIZE = 4, TAG_W = 3, DATA_W = 32, OP_W = 4, AGE_W = 3;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic clk_i = 1'b0;
    logic reset_i, flush_i, disp_valid_i, disp_ready_o;
    logic [OP_W-1:0] disp_op_i;
    logic [TAG_W-1:0] disp_dst_tag_i, disp_src1_tag_i, disp_src2_tag_i, cdb_tag_i;
    logic disp_src1_rdy_i, disp_src2_rdy_i, cdb_valid_i;
    logic [DATA_W-1:0] disp_src1_data_i, disp_src2_data_i, cdb_data_i;
    logic [SIZE-1:0] entry_free_o, entry_ready_o, entry_allocate_i, entry_issue_i;
    logic alloc_en_o, issue_valid_o, issue_ready_i;
    logic [SIZE*AGE_W-1:0] age_o;
    logic [OP_W-1:0] issue_op_o;
    logic [TAG_W-1:0] issue_dst_tag_o;
    logic [DATA_W-1:0] issue_src1_o, issue_src2_o;

    rs_entry_buffer #(.SIZE(SIZE), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .AGE_W(AGE_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_op_i(disp_op_i), .disp_dst_tag_i(disp_dst_tag_i),
        .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
        .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
        .disp_src1_data_i(disp_src1_data_i), .disp_src2_data_i(disp_src2_data_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .entry_free_o(entry_free_o), .entry_ready_o(entry_ready_o),
        .alloc_en_o(alloc_en_o), .age_o(age_o),
        .entry_allocate_i(entry_allocate_i), .entry_issue_i(entry_issue_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_op_o(issue_op_o), .issue_dst_tag_o(issue_dst_tag_o),
        .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each entry holds, and what the issue slot holds.
    bit               m_init = 0;
    bit               m_v  [SIZE];
    bit               m_r1 [SIZE];
    bit               m_r2 [SIZE];
    logic [OP_W-1:0]  m_op [SIZE];
    logic [TAG_W-1:0] m_dst[SIZE];
    logic [TAG_W-1:0] m_t1 [SIZE];
    logic [TAG_W-1:0] m_t2 [SIZE];
    logic [DATA_W-1:0] m_d1[SIZE];
    logic [DATA_W-1:0] m_d2[SIZE];
    int               m_age[SIZE];
    bit               s_v;
    logic [OP_W-1:0]  s_op;
    logic [TAG_W-1:0] s_dst;
    logic [DATA_W-1:0] s_d1, s_d2;

    function automatic int onehot_idx(input logic [SIZE-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < SIZE; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit model_has_free();
        for (int i = 0; i < SIZE; i++) if (!m_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk_i) begin
        int ai, gi;
        bit alloc, issue;
        if (reset_i || flush_i) begin
            for (int i = 0; i < SIZE; i++) begin
                m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_age[i] = 0;
            end
            s_v = 0; s_op = '0; s_dst = '0; s_d1 = '0; s_d2 = '0;
            m_init = 1;
        end else if (m_init) begin
            alloc = disp_valid_i && model_has_free();
            ai = alloc ? onehot_idx(entry_allocate_i) : -1;
            if (ai >= 0 && m_v[ai]) ai = -1;
            gi = onehot_idx(entry_issue_i);
            issue = (!s_v || issue_ready_i) && gi >= 0 && m_v[gi] && m_r1[gi] && m_r2[gi];
            if (issue) begin
                s_v = 1; s_op = m_op[gi]; s_dst = m_dst[gi]; s_d1 = m_d1[gi]; s_d2 = m_d2[gi];
            end else if (issue_ready_i) begin
                s_v = 0;
            end
            for (int i = 0; i < SIZE; i++) begin
                if (m_v[i] && !(issue && i == gi)) begin
                    if (cdb_valid_i && !m_r1[i] && m_t1[i] == cdb_tag_i) begin m_r1[i] = 1; m_d1[i] = cdb_data_i; end
                    if (cdb_valid_i && !m_r2[i] && m_t2[i] == cdb_tag_i) begin m_r2[i] = 1; m_d2[i] = cdb_data_i; end
                    if (alloc) m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
                end
            end
            if (issue) begin m_v[gi] = 0; m_age[gi] = 0; end
            if (ai >= 0) begin
                m_v[ai] = 1; m_age[ai] = 1; m_op[ai] = disp_op_i; m_dst[ai] = disp_dst_tag_i;
                m_t1[ai] = disp_src1_tag_i; m_t2[ai] = disp_src2_tag_i;
                m_r1[ai] = disp_src1_rdy_i || (cdb_valid_i && cdb_tag_i == disp_src1_tag_i);
                m_r2[ai] = disp_src2_rdy_i || (cdb_valid_i && cdb_tag_i == disp_src2_tag_i);
                m_d1[ai] = disp_src1_rdy_i ? disp_src1_data_i : cdb_data_i;
                m_d2[ai] = disp_src2_rdy_i ? disp_src2_data_i : cdb_data_i;
            end
        end
    end

    always @(negedge clk_i) begin
        logic [SIZE-1:0] ef, er;
        logic [SIZE*AGE_W-1:0] ea;
        bit any_free;
        if (m_init) begin
            any_free = model_has_free();
            for (int i = 0; i < SIZE; i++) begin
                ef[i] = !m_v[i];
                er[i] = m_v[i] && m_r1[i] && m_r2[i];
                ea[i*AGE_W +: AGE_W] = AGE_W'(m_age[i]);
            end
            chk("free", entry_free_o, ef);
            chk("ready", entry_ready_o, er);
            chk("age", age_o, ea);
            chk("disp_ready", disp_ready_o, any_free);
            chk("alloc_en", alloc_en_o, disp_valid_i && any_free);
            chk("issue_valid", issue_valid_o, s_v);
            chk("issue_op", issue_op_o, s_op);
            chk("issue_dst", issue_dst_tag_o, s_dst);
            chk("issue_src1", issue_src1_o, s_d1);
            chk("issue_src2", issue_src2_o, s_d2);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        disp_valid_i = 0; entry_allocate_i = '0; entry_issue_i = '0;
        cdb_valid_i = 0; flush_i = 0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dst,
                        input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                        input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2,
                        input logic [SIZE-1:0] sel);
        disp_valid_i = 1; disp_op_i = op; disp_dst_tag_i = dst;
        disp_src1_rdy_i = r1; disp_src1_tag_i = t1; disp_src1_data_i = d1;
        disp_src2_rdy_i = r2; disp_src2_tag_i = t2; disp_src2_data_i = d2;
        entry_allocate_i = sel;
    endtask

    initial begin
        reset_i = 1; issue_ready_i = 1; cdb_tag_i = '0; cdb_data_i = '0;
        disp(0, 0, 0, 0, 0, 0, 0, 0, '0);
        idle();
        step(); step();
        chk("rst_free", entry_free_o, 4'b1111);
        chk("rst_issue_valid", issue_valid_o, 0);
        chk("rst_disp_ready", disp_ready_o, 1);
        reset_i = 0;

        // Both operands ready at dispatch, then issue.
        disp(3, 5, 1, 0, 32'h11, 1, 0, 32'h22, 4'b0001);
        step(); idle();
        chk("s1_ready", entry_ready_o, 4'b0001);
        chk("s1_age0", age_o[2:0], 1);
        entry_issue_i = 4'b0001;
        step(); entry_issue_i = '0;
        chk("s1_issue_valid", issue_valid_o, 1);
        chk("s1_issue_dst", issue_dst_tag_o, 5);
        step();

        // src1 waits on tag 2, woken two cycles later.
        disp(1, 3, 0, 2, 0, 1, 0, 32'h7, 4'b0001);
        step(); idle();
        chk("s2_not_ready", entry_ready_o, 4'b0000);
        step();
        cdb_valid_i = 1; cdb_tag_i = 2; cdb_data_i = 32'hDEAD;
        step(); cdb_valid_i = 0;
        chk("s2_woken", entry_ready_o, 4'b0001);
        entry_issue_i = 4'b0001;
        step(); entry_issue_i = '0;
        chk("s2_src1", issue_src1_o, 32'hDEAD);
        step();

        // Dispatch-time bypass of src2.
        disp(2, 4, 1, 0, 32'h5, 0, 6, 0, 4'b0010);
        cdb_valid_i = 1; cdb_tag_i = 6; cdb_data_i = 32'h1234;
        step(); idle();
        chk("s3_ready", entry_ready_o, 4'b0010);
        entry_issue_i = 4'b0010;
        step(); entry_issue_i = '0;
        chk("s3_src2", issue_src2_o, 32'h1234);
        step();

        // Fill all four entries.
        for (int k = 0; k < SIZE; k++) begin
            disp(OP_W'(k + 8), TAG_W'(k + 1), 1, 0, DATA_W'(k * 16), 1, 0, DATA_W'(k * 16 + 1), SIZE'(1 << k));
            step();
        end
        idle();
        chk("s4_full", disp_ready_o, 0);
        chk("s4_ages", age_o, 12'b001_010_011_100);
        disp(9, 7, 1, 0, 0, 1, 0, 0, 4'b0001);
        #1;
        chk("s4_alloc_blocked", alloc_en_o, 0);
        step();
        chk("s4_still_full", entry_free_o, 4'b0000);
        idle();
        entry_issue_i = 4'b0001;
        step(); entry_issue_i = '0;
        chk("s4_freed", entry_free_o, 4'b0001);
        chk("s4_issue_dst", issue_dst_tag_o, 1);

        // Stalled slot ignores a grant until the consumer accepts.
        issue_ready_i = 0; entry_issue_i = 4'b0010;
        step();
        chk("s5_held_dst", issue_dst_tag_o, 1);
        chk("s5_entry1_kept", entry_free_o, 4'b0001);
        issue_ready_i = 1;
        step(); entry_issue_i = '0;
        chk("s5_issued_dst", issue_dst_tag_o, 2);
        chk("s5_freed", entry_free_o, 4'b0011);

        // Flush with three entries, a full slot and a dispatch in flight.
        disp(1, 6, 1, 0, 32'hA, 1, 0, 32'hB, 4'b0001);
        step(); idle();
        issue_ready_i = 0; entry_issue_i = 4'b0100;
        step(); entry_issue_i = '0;
        disp(1, 7, 1, 0, 32'hC, 1, 0, 32'hD, 4'b0010);
        step(); idle();
        chk("s6_pre_valid", issue_valid_o, 1);
        chk("s6_pre_free", entry_free_o, 4'b0100);
        flush_i = 1;
        disp(2, 3, 1, 0, 32'hE, 1, 0, 32'hF, 4'b0100);
        step(); idle();
        chk("s6_free", entry_free_o, 4'b1111);
        chk("s6_issue_valid", issue_valid_o, 0);
        chk("s6_age", age_o, 0);
        issue_ready_i = 1;

        // Age saturation: entry 0 sits while entries 1/2 churn through.
        disp(4, 1, 1, 0, 32'h1, 1, 0, 32'h2, 4'b0001);
        step();
        for (int j = 0; j < 9; j++) begin
            idle();
            disp(5, 2, 1, 0, DATA_W'(j), 1, 0, DATA_W'(j + 1), (j % 2 == 0) ? 4'b0010 : 4'b0100);
            entry_issue_i = (j == 0) ? 4'b0000 : ((j % 2 == 1) ? 4'b0010 : 4'b0100);
            step();
        end
        idle();
        chk("s7_age_sat", age_o[2:0], 3'd7);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_entry_buffer.md
Name: rs_entry_buffer

Overview:
- Reservation-station storage that sits on the opposite side of the priority/issue arbiter from dispatch.
- Accepts dispatched micro-ops into the free entry the arbiter selects, and captures operands from the common data bus (CDB).
- Publishes per-entry free, ready and age state to the arbiter.
- On the arbiter's one-hot issue grant, moves the granted entry into a registered issue slot toward the execution unit.

Parameters:
- SIZE, 4, number of entries; the arbiter's allocate and issue vectors are SIZE bits wide.
- TAG_W, 3, ROB/producer tag width.
- DATA_W, 32, operand width.
- OP_W, 4, opcode width.
- AGE_W, 3, per-entry age counter width.

Ports:
- clk_i, input, 1, the single clock.
- reset_i, input, 1, synchronous active-high reset.
- flush_i, input, 1, clears all entries and the issue slot.
- disp_valid_i, input, 1, dispatch request.
- disp_ready_o, output, 1, at least one entry is free.
- disp_op_i, input, OP_W, opcode.
- disp_dst_tag_i, input, TAG_W, destination tag.
- disp_src1_rdy_i / disp_src2_rdy_i, input, 1 each, operand already holds a value.
- disp_src1_tag_i / disp_src2_tag_i, input, TAG_W each, producer tag when the operand is not ready.
- disp_src1_data_i / disp_src2_data_i, input, DATA_W each, operand value when ready.
- cdb_valid_i, input, 1, result broadcast.
- cdb_tag_i, input, TAG_W, broadcast tag.
- cdb_data_i, input, DATA_W, broadcast value.
- entry_free_o, output, SIZE, entry unoccupied; feeds the arbiter's resource-valid input.
- entry_ready_o, output, SIZE, entry occupied with both operands ready.
- alloc_en_o, output, 1, disp_valid_i & disp_ready_o.
- age_o, output, SIZE*AGE_W, packed ages; entry i occupies bits [i*AGE_W +: AGE_W].
- entry_allocate_i, input, SIZE, one-hot free-entry choice from the arbiter.
- entry_issue_i, input, SIZE, one-hot issue grant from the arbiter.
- issue_valid_o, output, 1, issue slot holds an op.
- issue_ready_i, input, 1, execution unit accepts the op.
- issue_op_o, output, OP_W, issued opcode.
- issue_dst_tag_o, output, TAG_W, issued destination tag.
- issue_src1_o / issue_src2_o, output, DATA_W each, issued operand values.

Behaviour:
- Reset and flush:
  - Either one clears all entry valid bits at the next edge.
  - Resulting outputs: entry_free_o all ones, entry_ready_o 0, age_o 0, issue_valid_o 0, issue payload 0, disp_ready_o 1.
  - Flush has priority over dispatch, wakeup and issue in the same cycle; those events are dropped.
  - Reset has priority over flush.
- Registered status: entry_free_o, entry_ready_o and age_o come from registers only. An entry freed at edge N becomes allocatable in cycle N+1.
- Dispatch:
  - On alloc_en_o=1, the entry selected by entry_allocate_i loads at the edge with valid=1 and age=1.
  - Age starts at 1 because the arbiter uses a strict greater-than compare from 0; an entry with age 0 would never be selected.
  - If alloc_en_o=1 and entry_allocate_i is not one-hot on a free entry, nothing is written; this is a simulation assertion.
- Dispatch bypass: if a dispatched source is not ready and cdb_valid_i=1 with cdb_tag_i equal to its tag in the same cycle, the operand is stored as ready with cdb_data_i.
- Wakeup:
  - Every occupied entry compares each not-ready source tag with cdb_tag_i.
  - On a match it captures cdb_data_i and sets that source ready; entry_ready_o rises the next cycle.
  - Both sources may wake on the same broadcast.
- Ageing:
  - On each alloc_en_o=1 cycle, every occupied entry that is not issued that cycle increments its age.
  - Age saturates at 2^AGE_W-1.
  - A freed entry's age resets to 0.
- Issue slot (one-deep register):
  - slot_open = ~issue_valid_o | issue_ready_i.
  - When slot_open and entry_issue_i selects an occupied, ready entry, that entry's op/tag/operands load into the slot at the edge; the entry frees and its age clears.
  - A grant when the slot is not open, the bit points at an empty or unready entry, or the vector is not one-hot is ignored; the entry stays unchanged.
  - When issue_valid_o=1 and issue_ready_i=0, the payload holds stable.
  - When issue_ready_i=1 and there is no new grant, issue_valid_o drops at the edge.
  - Back-to-back issue gives 1 op per cycle.
- Latency:
  - Dispatch to entry_ready_o (operands ready at dispatch): 1 cycle.
  - Grant to issue_valid_o: 1 cycle.
- Simultaneous events:
  - Dispatch and issue in the same cycle are legal; they hit different entries by construction.
  - A CDB match on an entry being issued is irrelevant, because that entry is already ready.
- Full condition: all entries valid gives disp_ready_o=0; disp_valid_i is ignored and the request must be held by the sender.

Decomposition:
- Shared package rs_pkg:
  - Entry struct (valid, op, dst_tag, src{1,2}_rdy, src{1,2}_tag, src{1,2}_data, age).
  - Issue-payload struct.
  - Default width constants TAG_W, DATA_W, OP_W, AGE_W.
- One sub-module, rs_entry: a single entry's registers, wakeup comparators and age counter, instantiated SIZE times.

Test Plan:
- Reset, then dispatch op=3, dst=5, both sources ready, entry_allocate_i=0001 -> next cycle entry_ready_o=0001, age_o[2:0]=1; grant 0001 -> issue_valid_o=1, issue_dst_tag_o=5.
- Dispatch src1 waiting on tag 2; two cycles later cdb_tag_i=2, data=0xDEAD -> entry_ready_o bit set next cycle; issued issue_src1_o=0xDEAD.
- Dispatch with src2 tag 6 while cdb_tag_i=6, data=0x1234 in the same cycle -> entry ready 1 cycle later; issue_src2_o=0x1234.
- Fill 4 entries -> disp_ready_o=0 and extra dispatch dropped; ages read 4,3,2,1 for entries 0..3; issue entry 0 -> entry_free_o=0001 one cycle after the grant edge.
- Hold issue_ready_i=0 with slot full, assert grant 0010 -> grant ignored, payload unchanged, entry 1 still valid; raise issue_ready_i -> entry 1 issued next edge.
- flush_i asserted with 3 entries valid, a slot valid and a simultaneous dispatch -> next cycle entry_free_o=1111, issue_valid_o=0, age_o=0.
